machine_timer: RTL and testbench
================================

// Module: machine_timer
// PURPOSE
//  Memory-mapped machine timer peripheral; source of the timer interrupt delivered to clint on int_flag.
//  Prescaled 32-bit counter compared against a programmable value; a match latches a pending bit.
//  Bus-slave registers: control, prescaler, count, compare and status (write-1-to-clear).
//  Sits on the peripheral bus beside RAM/UART; int_flag feeds the core interrupt controller directly.
// PARAMETERS
//  INT_BIT  0   bit of int_flag driven by this timer; all other int_flag bits are 0
//  PSC_W    16  prescaler register/counter width
// PORTS
//  clk       in   1      system clock; all state updates on posedge
//  rst       in   1      asynchronous, active-low reset (rst==0 resets immediately)
//  req       in   1      bus access valid this cycle
//  we        in   1      write strobe, qualified by req
//  addr      in   32     byte address; only addr[4:2] decoded, upper bits decoded upstream
//  wdata     in   32     write data
//  rdata     out  32     read data, combinational from addr, 0 for unmapped offsets
//  int_flag  out  `IntBus  interrupt vector to clint; bit INT_BIT = pend & ie
// BEHAVIOUR
//  Register map (offset: field):
//   0x00 CTRL   [0] en, [1] ie, [2] periodic; other bits read 0
//   0x04 PSC    [PSC_W-1:0] divider; one tick every PSC+1 clk cycles
//   0x08 COUNT  32-bit current count, R/W
//   0x0C CMP    32-bit compare value, R/W
//   0x10 STATUS [0] pend; write 1 clears, write 0 no effect
//  Reset: CTRL=0, PSC=0, COUNT=0, CMP=32'hFFFF_FFFF, pend=0, psc_cnt=0; int_flag=0, rdata=reg at addr.
//  Writes take effect on the clk edge where req&we; reads have zero-cycle latency (rdata combinational).
//  Prescaler: psc_cnt increments while en; tick asserted for one cycle when psc_cnt==PSC, psc_cnt->0.
//   en==0 holds psc_cnt at 0; a PSC write or CTRL write clearing en resets psc_cnt to 0.
//  On tick: match = (COUNT==CMP).
//   match & periodic  -> COUNT<=0, pend<=1.
//   match & !periodic -> COUNT<=COUNT+1, pend<=1 (free-run; 32'hFFFF_FFFF wraps to 0, no carry flag).
//   no match          -> COUNT<=COUNT+1 with same wrap.
//  pend is sticky until cleared by STATUS write; ie gates only int_flag, never pend.
//  int_flag[INT_BIT] = pend & ie, driven from flops; visible the cycle after the matching tick edge.
//  Level semantics: clint sees int_flag!=0 until software clears pend or ie.
//  Simultaneous events:
//   STATUS W1C same cycle as match set -> set wins, pend stays 1.
//   COUNT write same cycle as tick -> written value wins; match still evaluated on old COUNT (may set pend).
//   CMP write same cycle as tick -> match uses old CMP.
//   CTRL en 1->0 on a tick cycle -> that tick still applied.
//  rst asserted mid-count -> all state returns to reset values asynchronously; int_flag drops same instant.
//  Writes with req=0 or to unmapped offsets ignored.
// STRUCTURE
//  defines.v: register offsets (`TIMER_CTRL..`TIMER_STATUS), CTRL bit indices, `IntBus, `INT_NONE.
//  Sub-module timer_prescaler (PSC_W): inputs en, psc, clr; output tick. Everything else in machine_timer.
// TESTING
//  1 Reset: drive rst=0 mid-run with COUNT=5, pend=1 -> all regs at reset values, int_flag=0 immediately.
//  2 PSC=3, CMP=2, CTRL=3'b011 free-run -> tick every 4 clk; pend at count 2, int_flag[INT_BIT]=1 next cycle, COUNT continues to 3.
//  3 Periodic: PSC=0, CMP=4, CTRL=3'b111 -> COUNT 0,1,2,3,4,0,... ; pend set every 5 clk; W1C STATUS clears int_flag.
//  4 Wrap: COUNT=32'hFFFF_FFFE, CMP=1, PSC=0, en=1 -> COUNT FFFF_FFFF, 0, 1; pend set on tick at COUNT=1.
//  5 Collision: W1C STATUS on same cycle as match -> pend remains 1; COUNT write 10 on tick cycle -> COUNT reads 10.
//  6 ie=0 with match -> pend=1, int_flag=0; then set ie=1 -> int_flag[INT_BIT]=1 next cycle; unmapped read 0x14 -> 0.

Source files
------------

// File: rtl/machine_timer_pkg.sv
// Shared definitions for the machine timer: register offsets, CTRL layout,
// interrupt bus width and reset constants.
package machine_timer_pkg;

  localparam int DATA_W = 32;
  localparam int INT_W  = 32;

  localparam logic [INT_W-1:0]  INT_NONE = '0;
  localparam logic [DATA_W-1:0] CMP_RST  = '1;

  // Word offsets, i.e. addr[4:2]
  typedef enum logic [2:0] {
    OFF_CTRL   = 3'd0,
    OFF_PSC    = 3'd1,
    OFF_COUNT  = 3'd2,
    OFF_CMP    = 3'd3,
    OFF_STATUS = 3'd4
  } reg_off_e;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IE  = 1;
  localparam int CTRL_PER = 2;

  typedef struct packed {
    logic periodic;
    logic ie;
    logic en;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] ctrl_to_word(ctrl_t c);
    return {{(DATA_W-3){1'b0}}, c};
  endfunction

endpackage

// File: rtl/machine_timer_prescaler.sv
// Clock divider for the machine timer: emits a one-cycle tick every PSC+1
// enabled cycles; counter is held at 0 while disabled or when cleared.
module timer_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [PSC_W-1:0] i_psc,
  output logic             o_tick
);

  logic [PSC_W-1:0] r_cnt;

  // Tick is combinational off the count so the core sees it in the same
  // cycle the count reaches PSC; an en drop that cycle does not suppress it.
  assign o_tick = i_en & (r_cnt == i_psc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_en || i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: prescaled 32-bit counter with compare match,
// sticky pending bit and a level interrupt onto the clint int_flag bus.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int INT_BIT = 0,
  parameter int PSC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [INT_W-1:0]  int_flag
);

  ctrl_t            r_ctrl;
  logic [PSC_W-1:0] r_psc;
  logic [31:0]      r_count;
  logic [31:0]      r_cmp;
  logic             r_pend;

  reg_off_e w_off;
  logic     w_wr;
  logic     w_wr_ctrl, w_wr_psc, w_wr_count, w_wr_cmp, w_wr_status;
  logic     w_tick, w_match, w_psc_clr;
  logic     w_unused_addr;

  assign w_off         = reg_off_e'(addr[4:2]);
  assign w_unused_addr = ^{addr[31:5], addr[1:0]};

  assign w_wr        = req & we;
  assign w_wr_ctrl   = w_wr & (w_off == OFF_CTRL);
  assign w_wr_psc    = w_wr & (w_off == OFF_PSC);
  assign w_wr_count  = w_wr & (w_off == OFF_COUNT);
  assign w_wr_cmp    = w_wr & (w_off == OFF_CMP);
  assign w_wr_status = w_wr & (w_off == OFF_STATUS);

  // Restart the divider on any PSC change or when software turns the timer off
  assign w_psc_clr = w_wr_psc | (w_wr_ctrl & ~wdata[CTRL_EN]);

  timer_prescaler #(
    .PSC_W (PSC_W)
  ) u_psc (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_ctrl.en),
    .i_clr  (w_psc_clr),
    .i_psc  (r_psc),
    .o_tick (w_tick)
  );

  // Match always compares the pre-edge COUNT/CMP, so same-cycle writes never mask it
  assign w_match = w_tick & (r_count == r_cmp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl <= '0;
      r_psc  <= '0;
      r_cmp  <= CMP_RST;
    end else begin
      if (w_wr_ctrl) r_ctrl <= ctrl_t'(wdata[2:0]);
      if (w_wr_psc)  r_psc  <= wdata[PSC_W-1:0];
      if (w_wr_cmp)  r_cmp  <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      r_count <= wdata;
    end else if (w_tick) begin
      r_count <= (w_match && r_ctrl.periodic) ? '0 : r_count + 32'd1;
    end
  end

  // Set beats a same-cycle W1C so a match is never lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= 1'b0;
    end else if (w_match) begin
      r_pend <= 1'b1;
    end else if (w_wr_status && wdata[0]) begin
      r_pend <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (w_off)
      OFF_CTRL:   rdata = ctrl_to_word(r_ctrl);
      OFF_PSC:    rdata = 32'(r_psc);
      OFF_COUNT:  rdata = r_count;
      OFF_CMP:    rdata = r_cmp;
      OFF_STATUS: rdata = {31'd0, r_pend};
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    int_flag          = INT_NONE;
    int_flag[INT_BIT] = r_pend & r_ctrl.ie;
  end

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: constant vector table, directed
// corner sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_machine_timer;
  import machine_timer_pkg::*;

  localparam int INT_BIT = 0;
  localparam int PSC_W   = 16;
  localparam int O_CTRL = 0, O_PSC = 1, O_COUNT = 2, O_CMP = 3, O_STATUS = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req = 1'b0;
  logic             we  = 1'b0;
  logic [31:0]      addr = '0;
  logic [31:0]      wdata = '0;
  logic [31:0]      rdata;
  logic [INT_W-1:0] int_flag;

  machine_timer #(.INT_BIT(INT_BIT), .PSC_W(PSC_W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .int_flag(int_flag)
  );

  always #50 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: register contents plus enabled cycles since restart
  logic [2:0]  m_ctrl;
  logic [15:0] m_psc;
  logic [31:0] m_count, m_cmp;
  bit          m_pend;
  longint      m_age;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_psc = '0; m_count = '0; m_cmp = 32'hFFFF_FFFF;
    m_pend = 0;  m_age = 0;
  endtask

  task automatic model_step(bit r, bit w, logic [31:0] a, logic [31:0] d);
    bit          wr    = r && w;
    logic [2:0]  off   = a[4:2];
    bit          en    = m_ctrl[0];
    longint      per   = longint'(m_psc) + 1;
    bit          tick  = en && ((m_age % per) == per - 1);
    bit          match = tick && (m_count == m_cmp);
    logic [31:0] ncnt  = m_count;
    if (tick) ncnt = (match && m_ctrl[2]) ? 32'd0 : m_count + 32'd1;
    if (wr && off == 3'd2) ncnt = d;
    if (match) m_pend = 1;
    else if (wr && off == 3'd4 && d[0]) m_pend = 0;
    if (!en || (wr && off == 3'd1) || (wr && off == 3'd0 && !d[0])) m_age = 0;
    else m_age = m_age + 1;
    m_count = ncnt;
    if (wr && off == 3'd0) m_ctrl = d[2:0];
    if (wr && off == 3'd1) m_psc = d[15:0];
    if (wr && off == 3'd3) m_cmp = d;
  endtask

  function automatic logic [31:0] mread(int off);
    case (off)
      0:       return {29'd0, m_ctrl};
      1:       return {16'd0, m_psc};
      2:       return m_count;
      3:       return m_cmp;
      4:       return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_int(bit p, bit ie);
    return (p && ie) ? (32'd1 << INT_BIT) : 32'd0;
  endfunction

  task automatic chk_reg(string name, int off, logic [31:0] exp);
    addr = 32'(off) << 2;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic model_check();
    for (int o = 0; o < 8; o++) chk_reg($sformatf("model_off%0d", o), o, mread(o));
    check("model_int", int_flag, exp_int(m_pend, m_ctrl[1]));
  endtask

  // One bus cycle: drive at negedge, model advances on the posedge, then compare
  task automatic cycle(bit r, bit w, logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    req = r; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_step(r, w, a, d);
    #1;
    req = 0; we = 0;
    model_check();
  endtask

  task automatic wr(int off, logic [31:0] d);
    cycle(1, 1, 32'(off) << 2, d);
  endtask

  task automatic idle(int n);
    repeat (n) cycle(0, 0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    #2 rst = 0;
    #2 rst = 1;
    model_reset();
  endtask

  typedef struct {
    bit          r;
    bit          w;
    int          off;
    logic [31:0] d;
    int          rd_off;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t tv(bit r, bit w, int off, logic [31:0] d, int ro,
                              logic [31:0] e, string n);
    vec_t v;
    v.r = r; v.w = w; v.off = off; v.d = d; v.rd_off = ro; v.exp = e; v.name = n;
    return v;
  endfunction

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq3[6] = '{1, 2, 3, 4, 0, 1};
    logic [31:0] seq4[4] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2};

    model_reset();
    #120 rst = 1;
    check("rst_int", int_flag, 32'd0);

    // Register access table, timer disabled throughout
    tbl.push_back(tv(0, 0, O_CTRL,   0,            O_CTRL,   32'd0,         "rst_ctrl"));
    tbl.push_back(tv(0, 0, O_CTRL,   0,            O_PSC,    32'd0,         "rst_psc"));
    tbl.push_back(tv(0, 0, O_CTRL,   0,            O_COUNT,  32'd0,         "rst_count"));
    tbl.push_back(tv(0, 0, O_CTRL,   0,            O_CMP,    32'hFFFF_FFFF, "rst_cmp"));
    tbl.push_back(tv(0, 0, O_CTRL,   0,            O_STATUS, 32'd0,         "rst_status"));
    tbl.push_back(tv(1, 1, O_PSC,    32'hABCD1234, O_PSC,    32'h0000_1234, "psc_trunc"));
    tbl.push_back(tv(1, 1, O_CMP,    32'h12345678, O_CMP,    32'h1234_5678, "cmp_rw"));
    tbl.push_back(tv(1, 1, O_COUNT,  32'd7,        O_COUNT,  32'd7,         "count_rw"));
    tbl.push_back(tv(0, 1, O_COUNT,  32'd99,       O_COUNT,  32'd7,         "we_no_req"));
    tbl.push_back(tv(1, 0, O_COUNT,  32'd55,       O_COUNT,  32'd7,         "req_no_we"));
    tbl.push_back(tv(1, 1, O_CTRL,   32'hFFFF_FFF8, O_CTRL,  32'd0,         "ctrl_hi_bits"));
    tbl.push_back(tv(1, 1, O_CTRL,   32'd6,        O_CTRL,   32'd6,         "ctrl_rw"));
    tbl.push_back(tv(1, 1, 5,        32'hFFFF_FFFF, 5,       32'd0,         "unmapped_14"));
    tbl.push_back(tv(1, 1, 7,        32'hFFFF_FFFF, O_COUNT, 32'd7,         "unmapped_1c"));
    tbl.push_back(tv(1, 1, O_STATUS, 32'd1,        O_STATUS, 32'd0,         "w1c_idle"));
    tbl.push_back(tv(1, 1, O_CTRL,   32'd0,        O_CTRL,   32'd0,         "ctrl_off"));
    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].w, 32'(tbl[i].off) << 2, tbl[i].d);
      chk_reg(tbl[i].name, tbl[i].rd_off, tbl[i].exp);
    end

    // Free-run with divide-by-4
    do_reset();
    wr(O_PSC, 3); wr(O_CMP, 2); wr(O_CTRL, 3);
    idle(3);  chk_reg("t2_pre_tick", O_COUNT, 32'd0);
    idle(1);  chk_reg("t2_first_tick", O_COUNT, 32'd1);
    idle(7);  chk_reg("t2_cnt2", O_COUNT, 32'd2);
    check("t2_int_before", int_flag, 32'd0);
    idle(1);  chk_reg("t2_cnt3", O_COUNT, 32'd3);
    chk_reg("t2_pend", O_STATUS, 32'd1);
    check("t2_int", int_flag, 32'd1 << INT_BIT);

    // Periodic reload, then W1C
    do_reset();
    wr(O_CMP, 4); wr(O_CTRL, 7);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk_reg($sformatf("t3_cnt%0d", i), O_COUNT, 32'(seq3[i]));
      chk_reg($sformatf("t3_pend%0d", i), O_STATUS, (i >= 4) ? 32'd1 : 32'd0);
    end
    wr(O_STATUS, 1);
    chk_reg("t3_w1c_pend", O_STATUS, 32'd0);
    check("t3_w1c_int", int_flag, 32'd0);
    chk_reg("t3_w1c_cnt", O_COUNT, 32'd2);

    // Wrap through all-ones
    do_reset();
    wr(O_COUNT, 32'hFFFF_FFFE); wr(O_CMP, 1); wr(O_CTRL, 1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk_reg($sformatf("t4_cnt%0d", i), O_COUNT, seq4[i]);
      chk_reg($sformatf("t4_pend%0d", i), O_STATUS, (i == 3) ? 32'd1 : 32'd0);
    end

    // Same-cycle collisions
    do_reset();
    wr(O_CMP, 3); wr(O_CTRL, 1);
    idle(3);  chk_reg("t5_cnt3", O_COUNT, 32'd3);
    wr(O_STATUS, 1);
    chk_reg("t5_set_wins", O_STATUS, 32'd1);
    chk_reg("t5_cnt4", O_COUNT, 32'd4);
    wr(O_COUNT, 10);
    chk_reg("t5_cnt_wr_wins", O_COUNT, 32'd10);
    wr(O_STATUS, 1);
    chk_reg("t5_clear", O_STATUS, 32'd0);
    wr(O_CMP, 11);
    chk_reg("t5_old_cmp", O_STATUS, 32'd0);
    chk_reg("t5_cnt12", O_COUNT, 32'd12);
    wr(O_CTRL, 0);
    chk_reg("t5_en_drop_tick", O_COUNT, 32'd13);
    idle(2);  chk_reg("t5_stopped", O_COUNT, 32'd13);

    // ie gating, then async reset with pend=1 and COUNT=5
    do_reset();
    wr(O_CMP, 2); wr(O_CTRL, 1);
    idle(3);
    chk_reg("t6_pend", O_STATUS, 32'd1);
    check("t6_int_masked", int_flag, 32'd0);
    wr(O_CTRL, 3);
    check("t6_int_on", int_flag, 32'd1 << INT_BIT);
    chk_reg("t6_unmapped", 5, 32'd0);
    wr(O_CTRL, 2); wr(O_COUNT, 5);
    chk_reg("t1_cnt5", O_COUNT, 32'd5);
    check("t1_int_pre", int_flag, 32'd1 << INT_BIT);
    #3 rst = 0;
    #1 check("t1_int_async", int_flag, 32'd0);
    chk_reg("t1_ctrl", O_CTRL, 32'd0);
    chk_reg("t1_count", O_COUNT, 32'd0);
    chk_reg("t1_cmp", O_CMP, 32'hFFFF_FFFF);
    chk_reg("t1_status", O_STATUS, 32'd0);
    #2 rst = 1;
    model_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      int          op  = $urandom_range(0, 9);
      int          off = $urandom_range(0, 7);
      logic [31:0] a   = ($urandom() & 32'hFFFF_FFE3) | (32'(off) << 2);
      logic [31:0] d   = $urandom();
      case (off)
        0: d = (d & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
        1: d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        2: d = m_cmp - 32'($urandom_range(0, 4));
        3: d = 32'($urandom_range(0, 12));
        4: d = 32'($urandom_range(0, 1));
        default: ;
      endcase
      if (op < 5) cycle(0, 1'($urandom_range(0, 1)), a, d);
      else        cycle(1, op != 9, a, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
